pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage register, successor to the fixed ID/EX-style latches in the 16-bit pipeline. It carries one PC, a data payload and a control word per instruction, with a 2-entry skid buffer and valid/ready handshake on both sides. It honours the global `stall_i` vector and `flush_i`, so one RTL body can be instanced between any two stages. Downstream sees a zeroed control word (NOP) whenever no instruction is valid, and the block keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage buffer:
// stage indices, occupancy encodings and reset/zero constants.
package pipe_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic [1:0] INC_ZERO = 2'd0;
    localparam logic [1:0] INC_ONE  = 2'd1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..3 increment per cycle.
// The synchronous clear doubles as the reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt_o} + {{(CNT_W-1){1'b0}}, inc};

    always_ff @(posedge clk_i) begin
        if (clr) begin
            cnt_o <= '0;
        end else if (sum[CNT_W]) begin
            cnt_o <= '1;
        end else begin
            cnt_o <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: main + skid entry, valid/ready on
// both sides, global stall/flush, saturating stall and flush counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 48,
    parameter int CTRL_W  = 10,
    parameter int STALL_W = 6,
    parameter int STAGE   = STG_EX,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [ADDR_W-1:0]  up_pc_i,
    input  logic [DATA_W-1:0]  up_data_i,
    input  logic [CTRL_W-1:0]  up_ctrl_i,
    output logic               dn_valid_o,
    input  logic               dn_ready_i,
    output logic [ADDR_W-1:0]  dn_pc_o,
    output logic [DATA_W-1:0]  dn_data_o,
    output logic [CTRL_W-1:0]  dn_ctrl_o,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    output logic [1:0]         occ_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    localparam int EW = ADDR_W + DATA_W + CTRL_W;

    occ_e          state;
    occ_e          state_nxt;
    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;
    logic [EW-1:0] in_ent;
    logic          push;
    logic          pop;
    logic          rst_act;
    logic [1:0]    stall_inc;
    logic [1:0]    flush_inc;
    logic          stall_unused;

    assign rst_act = (rst_i == RST_ENABLE);
    assign in_ent  = {up_pc_i, up_data_i, up_ctrl_i};
    assign push    = up_valid_i & up_ready_o & ~stall_i[STAGE];
    assign pop     = dn_valid_o & dn_ready_i & ~stall_i[STAGE+1];

    // Only two bits of the global vector matter to this instance.
    assign stall_unused = ^stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_act) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = OCC_EMPTY;
        end else begin
            unique case (state)
                OCC_EMPTY: if (push) state_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (push && !pop) begin
                        state_nxt = OCC_FULL;
                    end else if (pop && !push) begin
                        state_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL:  if (pop) state_nxt = OCC_ONE;
                default:   state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        up_ready_o = (state != OCC_FULL);
        dn_valid_o = (state != OCC_EMPTY);
        occ_o      = state;
    end

    // Invalid entries are kept all-zero so an idle output reads as a NOP.
    always_ff @(posedge clk_i) begin
        if (rst_act || flush_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state)
                OCC_EMPTY: if (push) main_q <= in_ent;
                OCC_ONE: begin
                    if (push && pop) begin
                        main_q <= in_ent;
                    end else if (push) begin
                        skid_q <= in_ent;
                    end else if (pop) begin
                        main_q <= '0;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    assign {dn_pc_o, dn_data_o, dn_ctrl_o} = main_q;

    assign stall_inc = (dn_valid_o & ~pop & ~flush_i) ? INC_ONE : INC_ZERO;
    assign flush_inc = flush_i ? occ_o : INC_ZERO;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr   (rst_act),
        .inc   (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr   (rst_act),
        .inc   (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed scenarios plus random
// traffic checked against a queue-based model of the held instructions.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 48;
    localparam int CW   = 10;
    localparam int SW   = 6;
    localparam int S    = 2;
    localparam int NW   = 4;
    localparam int MAXC = 15;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          up_valid_i = 1'b0;
    logic          up_ready_o;
    logic [AW-1:0] up_pc_i = '0;
    logic [DW-1:0] up_data_i = '0;
    logic [CW-1:0] up_ctrl_i = '0;
    logic          dn_valid_o;
    logic          dn_ready_i = 1'b0;
    logic [AW-1:0] dn_pc_o;
    logic [DW-1:0] dn_data_o;
    logic [CW-1:0] dn_ctrl_o;
    logic [SW-1:0] stall_i = '0;
    logic          flush_i = 1'b0;
    logic [1:0]    occ_o;
    logic [NW-1:0] stall_cnt_o;
    logic [NW-1:0] flush_cnt_o;

    int   checks = 0;
    int   errors = 0;
    int   held = 0;
    int   scnt = 0;
    int   fcnt = 0;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW),
        .STALL_W(SW), .STAGE(S), .CNT_W(NW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_pc_i     (up_pc_i),
        .up_data_i   (up_data_i),
        .up_ctrl_i   (up_ctrl_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_pc_o     (dn_pc_o),
        .dn_data_o   (dn_data_o),
        .dn_ctrl_o   (dn_ctrl_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .occ_o       (occ_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic ent_t mk(input logic [AW-1:0] pc,
                                input logic [DW-1:0] d,
                                input logic [CW-1:0] c);
        ent_t e;
        e.pc = pc;
        e.data = d;
        e.ctrl = c;
        return e;
    endfunction

    function automatic ent_t rnd();
        return mk(16'($urandom), {16'($urandom), $urandom()}, 10'($urandom));
    endfunction

    task automatic check_state();
        chk("occ", 64'(occ_o), 64'(held));
        chk("up_ready", 64'(up_ready_o), 64'(held < 2));
        chk("dn_valid", 64'(dn_valid_o), 64'(held > 0));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(scnt));
        chk("flush_cnt", 64'(flush_cnt_o), 64'(fcnt));
        if (held > 0 && exp_q.size() > 0) begin
            chk("head_pc", 64'(dn_pc_o), 64'(exp_q[0].pc));
            chk("head_ctrl", 64'(dn_ctrl_o), 64'(exp_q[0].ctrl));
        end
    endtask

    // One cycle: check registered state, then drive inputs and advance the model.
    task automatic step(input logic v, input ent_t e, input logic rdy,
                        input logic [SW-1:0] st, input logic fl,
                        output logic acc);
        bit p_pop;
        bit p_push;
        @(posedge clk);
        #1;
        check_state();
        up_valid_i = v;
        up_pc_i    = e.pc;
        up_data_i  = e.data;
        up_ctrl_i  = e.ctrl;
        dn_ready_i = rdy;
        stall_i    = st;
        flush_i    = fl;
        p_pop  = (held > 0) && rdy && !st[S+1];
        p_push = v && (held < 2) && !st[S];
        acc = p_push && !fl;
        if (fl) begin
            fcnt = sat(fcnt + held);
            exp_q.delete();
            held = 0;
        end else begin
            if (held > 0 && !p_pop) scnt = sat(scnt + 1);
            if (p_pop) held--;
            if (p_push) begin
                held++;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i      = 1'b0;
        up_valid_i = 1'b1;
        dn_ready_i = 1'b0;
        stall_i    = '0;
        flush_i    = 1'b0;
        @(posedge clk);
        #1;
        rst_i      = 1'b1;
        up_valid_i = 1'b0;
        held = 0;
        scnt = 0;
        fcnt = 0;
        exp_q.delete();
    endtask

    // Monitor: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_i) begin
            if (dn_valid_o && dn_ready_i && !stall_i[S+1] && !flush_i) begin
                chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", 64'(dn_pc_o), 64'(e.pc));
                    chk("out_data", 64'(dn_data_o), 64'(e.data));
                    chk("out_ctrl", 64'(dn_ctrl_o), 64'(e.ctrl));
                end
            end else if (!dn_valid_o) begin
                chk("bubble_ctrl", 64'(dn_ctrl_o), 64'(0));
                chk("bubble_pc", 64'(dn_pc_o), 64'(0));
                chk("bubble_data", 64'(dn_data_o), 64'(0));
            end
        end
    end

    initial begin
        ent_t z;
        ent_t c;
        logic acc;
        logic [SW-1:0] st;
        z = mk('0, '0, '0);

        do_reset();

        // single push, then idle
        step(1, mk(16'h0010, 48'h1234_5678_9ABC, 10'h3FF), 1, '0, 0, acc);
        step(0, z, 1, '0, 0, acc);
        step(0, z, 1, '0, 0, acc);

        // stream 8 back to back
        for (int i = 0; i < 8; i++) begin
            step(1, mk(16'(16'h0100 + i), 48'(i * 3), 10'(i + 1)), 1, '0, 0, acc);
        end
        step(0, z, 1, '0, 0, acc);

        // back-pressure: A, B absorbed, C held upstream
        step(1, mk(16'hA000, 48'hA, 10'h0A), 0, '0, 0, acc);
        step(1, mk(16'hB000, 48'hB, 10'h0B), 0, '0, 0, acc);
        c = mk(16'hC000, 48'hC, 10'h0C);
        for (int i = 0; i < 3; i++) step(1, c, 0, '0, 0, acc);
        for (int i = 0; i < 10; i++) begin
            step(1, c, 1, '0, 0, acc);
            if (acc) break;
        end
        for (int i = 0; i < 4; i++) step(0, z, 1, '0, 0, acc);

        // FULL plus flush with a live input
        step(1, rnd(), 0, '0, 0, acc);
        step(1, rnd(), 0, '0, 0, acc);
        step(1, rnd(), 1, '0, 1, acc);
        step(0, z, 1, '0, 0, acc);

        // upstream stalled, downstream free: drain then bubbles
        step(1, rnd(), 0, '0, 0, acc);
        st = '0;
        st[S] = 1'b1;
        for (int i = 0; i < 5; i++) step(1, rnd(), 1, st, 0, acc);
        step(0, z, 1, '0, 0, acc);

        // stall counter saturation
        step(1, rnd(), 0, '0, 0, acc);
        for (int i = 0; i < 20; i++) step(0, z, 0, '0, 0, acc);
        for (int i = 0; i < 3; i++) step(0, z, 1, '0, 0, acc);

        // reset mid-transfer discards contents
        step(1, rnd(), 0, '0, 0, acc);
        step(1, rnd(), 0, '0, 0, acc);
        do_reset();
        step(0, z, 1, '0, 0, acc);

        // random traffic, unrelated stall bits toggling freely
        for (int i = 0; i < 400; i++) begin
            st = SW'($urandom);
            st[S]   = ($urandom_range(0, 7) == 0);
            st[S+1] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 3) != 0, rnd(),
                 $urandom_range(0, 3) != 0, st,
                 $urandom_range(0, 19) == 0, acc);
        end
        for (int i = 0; i < 5; i++) step(0, z, 1, '0, 0, acc);
        @(posedge clk);
        #1;
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
